// File: rtl/down_counter_arbiter_if.sv
// Request/grant/countdown bundle between timer clients and the shared
// down-counter arbiter. The clients drive the master side and the arbiter
// drives the slave side.
interface down_counter_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int n     = 4
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]   req;
   logic [N_REQ*n-1:0] req_val;
   logic [N_REQ-1:0]   gnt;
   logic [N_REQ-1:0]   done;
   logic               busy;
   logic [ID_W-1:0]    cur_id;
   logic [n-1:0]       q;

   modport master (
      output req, req_val,
      input  gnt, done, busy, cur_id, q
   );

   modport slave (
      input  req, req_val,
      output gnt, done, busy, cur_id, q
   );
endinterface

// File: rtl/down_counter_arbiter.sv
// Shared down counter with round-robin arbitration. The winner's delay is
// loaded into the counter, counted down to 1 while its grant is held, and
// then acknowledged with a single-cycle done pulse. Dropping the winner's
// request while counting cancels the job without a done pulse.
module down_counter_arbiter #(
   parameter int N_REQ = 4,
   parameter int n     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   down_counter_arbiter_if.slave bus
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_r, state_s;
   logic [n-1:0]     q_r, q_s;
   logic [N_REQ-1:0] gnt_r, gnt_s;
   logic [N_REQ-1:0] done_r, done_s;
   logic             busy_r, busy_s;
   logic [ID_W-1:0]  cur_id_r, cur_id_s;
   logic [ID_W-1:0]  ptr_r, ptr_s;
   logic [ID_W-1:0]  win_s;
   logic [n-1:0]     win_val_s;

   // First set request bit scanning upward from just after the last winner.
   function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  p);
      logic [ID_W-1:0] pick;
      logic            found;
      int              idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(p) + k) % N_REQ;
         if (!found && r[ID_W'(idx)]) begin
            pick  = ID_W'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] i);
      logic [N_REQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   assign win_s     = rr_pick(bus.req, ptr_r);
   assign win_val_s = bus.req_val[int'(win_s)*n +: n];

   // Next-state and next-output decode for the arbitration/count FSM.
   always_comb begin
      state_s  = state_r;
      q_s      = q_r;
      gnt_s    = gnt_r;
      done_s   = '0;
      cur_id_s = cur_id_r;
      ptr_s    = ptr_r;
      case (state_r)
         IDLE: begin
            if (|bus.req) begin
               cur_id_s = win_s;
               q_s      = win_val_s;
               if (win_val_s != '0) begin
                  state_s = COUNT;
                  gnt_s   = onehot(win_s);
               end else begin
                  // Zero delay completes immediately without a grant.
                  state_s = DONE;
                  gnt_s   = '0;
                  done_s  = onehot(win_s);
               end
            end else begin
               q_s   = '0;
               gnt_s = '0;
            end
         end
         COUNT: begin
            if (!bus.req[cur_id_r]) begin
               // Cancel outranks completion; no done for an aborted job.
               state_s = IDLE;
               q_s     = '0;
               gnt_s   = '0;
               ptr_s   = cur_id_r;
            end else if (q_r == n'(1)) begin
               state_s = DONE;
               q_s     = '0;
               gnt_s   = '0;
               done_s  = onehot(cur_id_r);
            end else begin
               q_s = q_r - n'(1);
            end
         end
         DONE: begin
            state_s = IDLE;
            q_s     = '0;
            gnt_s   = '0;
            ptr_s   = cur_id_r;
         end
         default: begin
            state_s = IDLE;
            q_s     = '0;
            gnt_s   = '0;
         end
      endcase
      busy_s = (state_s != IDLE);
   end

   // State and output registers; reset wins over any in-flight job.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         q_r      <= '0;
         gnt_r    <= '0;
         done_r   <= '0;
         busy_r   <= 1'b0;
         cur_id_r <= '0;
         ptr_r    <= ID_W'(N_REQ - 1);
      end else begin
         state_r  <= state_s;
         q_r      <= q_s;
         gnt_r    <= gnt_s;
         done_r   <= done_s;
         busy_r   <= busy_s;
         cur_id_r <= cur_id_s;
         ptr_r    <= ptr_s;
      end
   end

   assign bus.q      = q_r;
   assign bus.gnt    = gnt_r;
   assign bus.done   = done_r;
   assign bus.busy   = busy_r;
   assign bus.cur_id = cur_id_r;
endmodule

// File: tb/tb_down_counter_arbiter.sv
// Bench for down_counter_arbiter: directed scenarios with literal
// expectations, then randomized requests, delays and resets, with every
// cycle compared against a job-level reference model.
module tb_down_counter_arbiter;
   localparam int NR  = 4;
   localparam int NW  = 4;
   localparam int IDW = $clog2(NR);

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   down_counter_arbiter_if #(.N_REQ(NR), .n(NW)) bus ();

   down_counter_arbiter #(.N_REQ(NR), .n(NW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: one job at a time, tracked by owner and remaining time.
   logic          m_valid;
   logic          m_active;
   logic          m_done;
   int            m_left;
   int            m_id;
   int            m_last;
   int            m_win;
   logic          m_any;
   logic [NW-1:0] m_val;

   logic [NR-1:0]  exp_gnt;
   logic [NR-1:0]  exp_done;
   logic           exp_busy;
   logic [NW-1:0]  exp_q;
   logic [IDW-1:0] exp_id;

   assign exp_gnt  = m_active ? (NR'(1) << m_id) : '0;
   assign exp_done = m_done ? (NR'(1) << m_id) : '0;
   assign exp_busy = m_active | m_done;
   assign exp_q    = m_active ? NW'(m_left) : '0;
   assign exp_id   = IDW'(m_id);

   // Arbitration order: requesters after the last finished/cancelled owner.
   always_comb begin
      m_win = 0;
      m_any = 1'b0;
      for (int k = 1; k <= NR; k++) begin
         if (!m_any && bus.req[IDW'((m_last + k) % NR)]) begin
            m_win = (m_last + k) % NR;
            m_any = 1'b1;
         end
      end
      m_val = bus.req_val[m_win*NW +: NW];
   end

   // Advance the model once per clock using the same sampled inputs.
   always @(posedge clk) begin
      if (rst) begin
         m_valid  <= 1'b1;
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_left   <= 0;
         m_id     <= 0;
         m_last   <= NR - 1;
      end else if (m_done) begin
         m_done <= 1'b0;
         m_last <= m_id;
      end else if (m_active) begin
         if (!bus.req[IDW'(m_id)]) begin
            m_active <= 1'b0;
            m_last   <= m_id;
         end else if (m_left == 1) begin
            m_active <= 1'b0;
            m_done   <= 1'b1;
         end else begin
            m_left <= m_left - 1;
         end
      end else if (m_any) begin
         m_id <= m_win;
         if (m_val != '0) begin
            m_active <= 1'b1;
            m_left   <= int'(m_val);
         end else begin
            m_done <= 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
      end
   endtask

   // Literal expectation applied to both the DUT and the model.
   task automatic lit(input string name, input logic [31:0] dut_v,
                      input logic [31:0] mod_v, input logic [31:0] want);
      chk({name, "_dut"}, dut_v, want);
      chk({name, "_model"}, mod_v, want);
   endtask

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
         chk("done", 32'(bus.done), 32'(exp_done));
         chk("busy", 32'(bus.busy), 32'(exp_busy));
         chk("q", 32'(bus.q), 32'(exp_q));
         chk("cur_id", 32'(bus.cur_id), 32'(exp_id));
         chk("gnt_done_excl", 32'((|bus.gnt) & (|bus.done)), 32'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_val(input int i, input int v);
      bus.req_val[i*NW +: NW] = NW'(v);
   endtask

   initial begin
      m_valid     = 1'b0;
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      bus.req     = '0;
      bus.req_val = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      lit("rst_q", 32'(bus.q), 32'(exp_q), 32'd0);
      lit("rst_busy", 32'(bus.busy), 32'(exp_busy), 32'd0);
      lit("rst_id", 32'(bus.cur_id), 32'(exp_id), 32'd0);
      rst = 1'b0;

      // Single request, delay 3.
      bus.req = 4'b0001;
      set_val(0, 3);
      for (int i = 0; i < 3; i++) begin
         step();
         lit("single_q", 32'(bus.q), 32'(exp_q), 32'(3 - i));
         lit("single_gnt", 32'(bus.gnt), 32'(exp_gnt), 32'h1);
      end
      step();
      lit("single_done", 32'(bus.done), 32'(exp_done), 32'h1);
      lit("single_done_q", 32'(bus.q), 32'(exp_q), 32'd0);
      bus.req = '0;
      step();
      lit("single_idle", 32'(bus.busy), 32'(exp_busy), 32'd0);

      // Zero delay: done without a grant.
      bus.req = 4'b0100;
      set_val(2, 0);
      step();
      lit("zero_done", 32'(bus.done), 32'(exp_done), 32'h4);
      lit("zero_gnt", 32'(bus.gnt), 32'(exp_gnt), 32'h0);
      lit("zero_busy", 32'(bus.busy), 32'(exp_busy), 32'd1);
      bus.req = '0;
      step();
      lit("zero_idle", 32'(bus.busy), 32'(exp_busy), 32'd0);

      // Abort at q=5 with requester 2 pending.
      bus.req = 4'b0010;
      set_val(1, 8);
      step();
      lit("abort_load", 32'(bus.q), 32'(exp_q), 32'd8);
      bus.req = 4'b0110;
      set_val(2, 6);
      repeat (3) step();
      lit("abort_q5", 32'(bus.q), 32'(exp_q), 32'd5);
      bus.req = 4'b0100;
      step();
      lit("abort_idle_q", 32'(bus.q), 32'(exp_q), 32'd0);
      lit("abort_idle_done", 32'(bus.done), 32'(exp_done), 32'd0);
      lit("abort_idle_busy", 32'(bus.busy), 32'(exp_busy), 32'd0);
      step();
      lit("abort_next_gnt", 32'(bus.gnt), 32'(exp_gnt), 32'h4);
      lit("abort_next_q", 32'(bus.q), 32'(exp_q), 32'd6);

      // Reset mid-count, then round-robin over all requesters.
      rst     = 1'b1;
      bus.req = 4'b1111;
      for (int i = 0; i < NR; i++) set_val(i, 2);
      step();
      lit("midrst_q", 32'(bus.q), 32'(exp_q), 32'd0);
      lit("midrst_gnt", 32'(bus.gnt), 32'(exp_gnt), 32'd0);
      lit("midrst_busy", 32'(bus.busy), 32'(exp_busy), 32'd0);
      rst = 1'b0;
      step();
      lit("rr_id0", 32'(bus.cur_id), 32'(exp_id), 32'd0);
      lit("rr_gnt0", 32'(bus.gnt), 32'(exp_gnt), 32'h1);
      for (int g = 1; g <= 4; g++) begin
         repeat (4) step();
         lit("rr_id", 32'(bus.cur_id), 32'(exp_id), 32'(g % NR));
         lit("rr_gnt", 32'(bus.gnt), 32'(exp_gnt), 32'(1 << (g % NR)));
      end
      bus.req = '0;
      step();

      // Maximum delay: no wrap on the way down.
      bus.req = 4'b1000;
      set_val(3, 15);
      step();
      for (int i = 0; i < 15; i++) begin
         lit("max_q", 32'(bus.q), 32'(exp_q), 32'(15 - i));
         lit("max_gnt", 32'(bus.gnt), 32'(exp_gnt), 32'h8);
         step();
      end
      lit("max_done", 32'(bus.done), 32'(exp_done), 32'h8);
      lit("max_done_q", 32'(bus.q), 32'(exp_q), 32'd0);
      bus.req = '0;
      step();

      // Randomized requests, cancels, delays and occasional resets.
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < NR; i++) begin
            if ($urandom_range(0, 9) == 0) bus.req[IDW'(i)] = ~bus.req[IDW'(i)];
            if ($urandom_range(0, 3) == 0) begin
               if ($urandom_range(0, 3) == 0) set_val(i, int'($urandom_range(0, 15)));
               else set_val(i, int'($urandom_range(0, 4)));
            end
         end
         step();
      end
      rst     = 1'b0;
      bus.req = '0;
      repeat (20) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/down_counter_arbiter.md
Name: down_counter_arbiter

Overview:
- Shares one synchronous down counter between N_REQ requesters that each need a programmable delay.
- Arbitrates requests round-robin and loads the winner's delay value into the counter.
- Counts down to zero, then pulses a per-requester done.
- Sits between timer clients and the shared countdown datapath.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- n, 4, counter and delay-value width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester request level; held high until done or to cancel.
- req_val  input  N_REQ*n  flattened delay values; requester i uses bits [i*n +: n]; sampled only at grant.
- gnt  output  N_REQ  one-hot grant; high only in COUNT.
- done  output  N_REQ  one-cycle completion pulse to the winner.
- busy  output  1  high whenever state != IDLE.
- cur_id  output  $clog2(N_REQ)  index of the current/last winner.
- q  output  n  shared counter value.

Behaviour:
- Reset (synchronous, dominant in any state, including mid-count):
  - state=IDLE, q=0, gnt=0, done=0, busy=0, cur_id=0.
  - Round-robin pointer ptr=N_REQ-1, so requester 0 has first priority.
  - No done pulse is issued for an interrupted job.
- States: IDLE, COUNT, DONE.
- IDLE:
  - If req==0, remain in IDLE with q=0.
  - Otherwise the winner w is the first set req bit scanning ptr+1, ptr+2, ... modulo N_REQ.
  - The next edge latches cur_id=w and q=req_val[w].
  - If that value is nonzero, go to COUNT with gnt=onehot(w).
  - If that value is 0, go directly to DONE with gnt=0.
- COUNT:
  - Each cycle q<=q-1 and gnt is held.
  - When q==1, the next cycle enters DONE with q=0 and gnt=0.
  - Abort: if req[w]==0 is sampled in COUNT, the next cycle is IDLE with q=0, gnt=0 and no done. ptr<=w.
  - Abort has priority over the q==1 transition.
  - req from non-winners is ignored while in COUNT.
- DONE:
  - done[w]=1 for exactly this cycle, q=0, ptr<=w.
  - The next state is always IDLE.
- Timing for req first seen in IDLE at cycle t with value V>0:
  - COUNT spans cycles t+1..t+V, with q=V..1.
  - DONE is at t+V+1.
  - IDLE is at t+V+2, where the next arbitration is sampled.
  - The next COUNT starts at t+V+3.
- Timing for V=0: DONE is at t+1 and IDLE at t+2.
- A requester that keeps req high after its done re-enters arbitration at the lowest priority.
- Arithmetic:
  - q is unsigned n-bit.
  - The decrement never wraps, because COUNT exits at q==1.
  - The maximum delay is 2^n-1 cycles.
- Output encoding:
  - gnt and done are one-hot or zero, and are never both nonzero in the same cycle.
  - cur_id holds its value through IDLE until the next grant.

Test Plan:
- Single request, normal delay:
  - Stimulus: after reset, req=4'b0001, val0=3.
  - Response: q=3,2,1 with gnt=0001 for 3 cycles, then done=0001 for one cycle with q=0, then busy=0.
- Round-robin ordering:
  - Stimulus: req=4'b1111 held, all vals=2.
  - Response: grants in order 0,1,2,3,0; each job takes 4 cycles (2 COUNT + DONE + IDLE); cur_id follows.
- Zero delay:
  - Stimulus: req=4'b0100, val2=0.
  - Response: no gnt; done=0100 one cycle after the request is sampled; q stays 0.
- Abort:
  - Stimulus: req1 with val1=8; drop req1 when q=5.
  - Response: next cycle is IDLE, q=0, gnt=0, no done; a pending req2 is granted next.
- Reset mid-count:
  - Stimulus: assert rst while q=6.
  - Response: next edge gives q=0, gnt=0, done=0, busy=0; the first grant after reset goes to req0 when all requesters are high.
- Maximum value, n=4:
  - Stimulus: val=15.
  - Response: 15 COUNT cycles ending at q=1, then q=0 in DONE; q never shows 4'b1111 after the load, so there is no wrap.
